// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 encodings,
// FSM state type, latched request payload and the legal-request helper.
package dmem_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned F3_W   = 3;

  localparam logic [F3_W-1:0] F3_BYTE  = 3'b000;
  localparam logic [F3_W-1:0] F3_WORD  = 3'b010;
  localparam logic [F3_W-1:0] F3_BYTEU = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  // Request fields captured at accept time
  typedef struct packed {
    logic              we;
    logic [F3_W-1:0]   funct3;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  // Only LW, SW, LBU (load) and SB (store) are supported
  function automatic logic req_legal(input logic we, input logic [F3_W-1:0] funct3);
    logic ok;
    ok = 1'b0;
    if (funct3 == F3_WORD) ok = 1'b1;
    else if (funct3 == F3_BYTEU && !we) ok = 1'b1;
    else if (funct3 == F3_BYTE && we) ok = 1'b1;
    return ok;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational little-endian byte-lane helper.
// Ports:
//   word         current RAM word
//   lane         byte lane (addr[1:0])
//   byte_in      store byte (wdata[7:0])
//   store_word_c word with the selected lane replaced by byte_in
//   load_word_c  selected lane zero-extended to 32 bits
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [DATA_W-1:0] word,
  input  logic [1:0]        lane,
  input  logic [7:0]        byte_in,
  output logic [DATA_W-1:0] store_word_c,
  output logic [DATA_W-1:0] load_word_c
);

  logic [4:0]        shift;
  logic [DATA_W-1:0] mask;
  logic [DATA_W-1:0] shifted;

  // Lane select, merge mask and extraction
  always_comb begin
    shift        = {lane, 3'b000};
    mask         = DATA_W'(32'h0000_00FF) << shift;
    store_word_c = (word & ~mask) | (DATA_W'(byte_in) << shift);
    shifted      = word >> shift;
    load_word_c  = {24'b0, shifted[7:0]};
  end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for CPU load/store requests. One request at a time
// over valid/ready; executes LW/LBU/SW/SB against an internal word RAM after
// a fixed access latency and returns read data or a store acknowledge.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_ready      request handshake (ready only in IDLE)
//   req_we/req_funct3        operation select
//   req_addr/req_wdata       byte address and store data
//   rsp_valid/rsp_ready      response handshake
//   rsp_rdata/rsp_err        load data (0 for stores/errors), reject flag
module data_mem_responder #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  import dmem_pkg::*;

  localparam int unsigned IDX_W = ADDR_WIDTH - 2;
  localparam int unsigned WORDS = 1 << IDX_W;
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  if (LATENCY == 0) begin : g_bad_latency
    $error("data_mem_responder: LATENCY must be at least 1");
  end
  if (ADDR_WIDTH < 3 || ADDR_WIDTH > 31) begin : g_bad_addr_width
    $error("data_mem_responder: ADDR_WIDTH must be in 3..31");
  end

  state_t            state;
  req_t              lat;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] mem [WORDS];

  logic [IDX_W-1:0]  idx;
  logic [1:0]        lane;
  logic              err;
  logic              commit;
  logic              mem_we;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] merged_word;
  logic [DATA_W-1:0] byte_word;
  logic [DATA_W-1:0] commit_rdata;
  logic [DATA_W-1:0] wr_word;

  assign idx     = lat.addr[ADDR_WIDTH-1:2];
  assign lane    = lat.addr[1:0];
  assign rd_word = mem[idx];
  assign commit  = (state == S_ACCESS) && (cnt == '0);

  // Reject illegal op pairs, misaligned words and addresses beyond the RAM
  always_comb begin
    err = 1'b0;
    if (!req_legal(lat.we, lat.funct3)) err = 1'b1;
    if (lat.funct3 == F3_WORD && lane != 2'b00) err = 1'b1;
    if (lat.addr[31:ADDR_WIDTH] != '0) err = 1'b1;
  end

  dmem_lane_align u_lane_align (
    .word         (rd_word),
    .lane         (lane),
    .byte_in      (lat.wdata[7:0]),
    .store_word_c (merged_word),
    .load_word_c  (byte_word)
  );

  // Commit-cycle read data and write enable; nothing happens on error
  always_comb begin
    commit_rdata = '0;
    wr_word      = lat.wdata;
    mem_we       = 1'b0;
    if (commit && !err && !rst) begin
      if (lat.we) begin
        mem_we = 1'b1;
        if (lat.funct3 == F3_BYTE) wr_word = merged_word;
      end else begin
        commit_rdata = (lat.funct3 == F3_WORD) ? rd_word : byte_word;
      end
    end
  end

  // RAM contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx] <= wr_word;
  end

  // Request/response FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      lat       <= '0;
      cnt       <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            lat       <= '{we: req_we, funct3: req_funct3, addr: req_addr, wdata: req_wdata};
            cnt       <= CNT_W'(LATENCY - 1);
            req_ready <= 1'b0;
            state     <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (cnt == '0) begin
            rsp_rdata <= commit_rdata;
            rsp_err   <= err;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
